// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer of the 32-bit dual-clock FIFO, entirely in the FIFO read
// clock domain. Words are popped with the FIFO's normal-mode (non-show-ahead)
// protocol, so read data arrives one cycle after an accepted rdreq. They land
// in a 3-entry skid buffer and leave as a valid/ready stream framed into
// fixed-length packets.
//
// Ports:
//   rdclk        read-domain clock
//   aclr         asynchronous active-high reset
//   rd_en        enables issuing new FIFO reads (in-flight/buffered words still drain)
//   fifo_q       FIFO read data, valid the cycle after an accepted rdreq
//   fifo_rdempty FIFO empty flag
//   fifo_rdreq   FIFO read request
//   out_data     stream data (head of the skid buffer)
//   out_valid    stream data valid
//   out_ready    downstream accept
//   out_sop      first beat of a packet, qualified by out_valid
//   out_eop      last beat of a packet, qualified by out_valid
//   beat_cnt     index of the current beat within the packet
module fifo_rd_stream #(
   parameter int DATA_W  = 32,
   parameter int PKT_LEN = 256,
   parameter int CNT_W   = 16
) (
   input  logic              rdclk,
   input  logic              aclr,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] fifo_q,
   input  logic              fifo_rdempty,
   output logic              fifo_rdreq,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [CNT_W-1:0]  beat_cnt
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

   logic [DATA_W-1:0] mem [3];
   logic [1:0]        head;
   logic [1:0]        tail;
   logic [1:0]        count;
   logic              inflight;
   logic              push;
   logic              pop;
   logic [2:0]        occupancy;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] beat_next(input logic [CNT_W-1:0] b);
      return (b == LAST_BEAT) ? '0 : b + CNT_W'(1);
   endfunction

   // A word already requested will land next cycle, so it reserves a slot now.
   // Limiting buffered + in-flight to 2 before issuing keeps the buffer from
   // overflowing even if downstream stalls forever. out_ready is deliberately
   // not part of this term so no combinational path runs from it to rdreq.
   assign occupancy  = {1'b0, count} + {2'b00, inflight};
   assign fifo_rdreq = ~aclr & rd_en & ~fifo_rdempty & (occupancy <= 3'd2);

   assign push      = inflight;
   assign pop       = out_valid & out_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[head];
   assign out_sop   = (beat_cnt == '0);
   assign out_eop   = (beat_cnt == LAST_BEAT);

   // Control: in-flight flag, buffer pointers/count, packet beat counter
   always_ff @(posedge rdclk or posedge aclr) begin
      if (aclr) begin
         inflight <= 1'b0;
         head     <= 2'd0;
         tail     <= 2'd0;
         count    <= 2'd0;
         beat_cnt <= '0;
      end else begin
         inflight <= fifo_rdreq;
         if (push) tail <= ptr_next(tail);
         if (pop)  head <= ptr_next(head);
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (pop) beat_cnt <= beat_next(beat_cnt);
      end
   end

   // Storage: cleared on reset so out_data reads zero until the first word
   always_ff @(posedge rdclk or posedge aclr) begin
      if (aclr) begin
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else if (push) begin
         mem[tail] <= fifo_q;
      end
   end

   // A word arriving while all three slots are occupied would be lost.
   a_no_overflow: assert property (@(posedge rdclk) disable iff (aclr)
      !(push && count == 2'd3));

endmodule

// File: tb/tb_fifo_rd_stream.sv
`timescale 1ns/1ps
module tb_fifo_rd_stream;

   localparam int DW  = 32;
   localparam int PKT = 4;
   localparam int CW  = 16;

   logic          rdclk = 1'b0;
   logic          aclr = 1'b1;
   logic          rd_en = 1'b0;
   logic          out_ready = 1'b0;
   logic          fifo_rdempty = 1'b1;
   logic [DW-1:0] fifo_q = '0;

   logic          fifo_rdreq, out_valid, out_sop, out_eop;
   logic [DW-1:0] out_data;
   logic [CW-1:0] beat_cnt;

   logic          rdreq1, valid1, sop1, eop1;
   logic [DW-1:0] data1;
   logic [3:0]    beat1;

   fifo_rd_stream #(.DATA_W(DW), .PKT_LEN(PKT), .CNT_W(CW)) dut (
      .rdclk(rdclk), .aclr(aclr), .rd_en(rd_en), .fifo_q(fifo_q),
      .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
      .out_eop(out_eop), .beat_cnt(beat_cnt));

   // Same stimulus, single-beat packets
   fifo_rd_stream #(.DATA_W(DW), .PKT_LEN(1), .CNT_W(4)) dut1 (
      .rdclk(rdclk), .aclr(aclr), .rd_en(rd_en), .fifo_q(fifo_q),
      .fifo_rdempty(fifo_rdempty), .fifo_rdreq(rdreq1), .out_data(data1),
      .out_valid(valid1), .out_ready(out_ready), .out_sop(sop1),
      .out_eop(eop1), .beat_cnt(beat1));

   always #5 rdclk = ~rdclk;

   int            n_chk = 0;
   int            n_fail = 0;
   int            n_pop = 0;
   logic [DW-1:0] src[$];     // words waiting in the upstream FIFO
   logic [DW-1:0] exp_q[$];   // words read from the FIFO, not yet delivered
   logic          req_prev = 1'b0;
   int            idx = 0;    // expected beat index within the packet
   logic          stall = 1'b0;
   logic [DW-1:0] stall_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle: FIFO model answers last cycle's request, inputs are applied
   // on the falling edge and this cycle's request is sampled before the rising edge.
   task automatic step(input logic en, input logic rdy, input logic rst);
      @(negedge rdclk);
      if (req_prev && src.size() != 0) begin
         fifo_q = src.pop_front();
         exp_q.push_back(fifo_q);
      end else begin
         fifo_q = $urandom;
      end
      fifo_rdempty = (src.size() == 0);
      rd_en = en;
      out_ready = rdy;
      aclr = rst;
      if (rst) exp_q.delete();
      #1;
      req_prev = fifo_rdreq;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((src.size() != 0 || exp_q.size() != 0 || req_prev || out_valid) && n < 2000) begin
         step(1'b1, 1'b1, 1'b0);
         n++;
      end
      check({name, "_drain_timeout"}, n < 2000, 1);
   endtask

   // Monitor / scoreboard
   always begin
      @(negedge rdclk);
      #2;
      if (aclr) begin
         idx = 0;
         stall = 1'b0;
      end else begin
         check("beat_cnt", beat_cnt, idx);
         check("pkt1_beat_cnt", beat1, 0);
         if (stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, stall_data);
         end
         if (out_valid) begin
            check("sop", out_sop, idx == 0);
            check("eop", out_eop, idx == PKT - 1);
         end
         if (valid1) begin
            check("pkt1_sop", sop1, 1);
            check("pkt1_eop", eop1, 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", out_data, 64'hdead_0000);
            else check("data", out_data, exp_q.pop_front());
            n_pop++;
            idx = (idx + 1) % PKT;
         end
         stall = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   initial begin
      int npulse;
      int sent;
      int n;
      int p0;

      // Reset with words already waiting: rdreq must still stay low
      for (int i = 0; i < 8; i++) src.push_back(DW'(i));
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_valid", out_valid, 0);
      check("rst_sop", out_sop, 1);
      check("rst_eop", out_eop, 0);
      check("rst_beat", beat_cnt, 0);
      check("rst_data", out_data, 0);
      check("rst_rdreq", fifo_rdreq, 0);
      check("pkt1_rst_eop", eop1, 1);

      // Latency and full-rate streaming
      step(1'b1, 1'b1, 1'b0);
      check("first_rdreq", req_prev, 1);
      step(1'b1, 1'b1, 1'b0);
      check("latency_t1_valid", out_valid, 0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check("stream_valid", out_valid, 1);
      end
      drain("p1");

      // Backpressure with a full upstream FIFO
      for (int i = 0; i < 16; i++) src.push_back(DW'(32'h100 + i));
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0);
         npulse += int'(req_prev);
      end
      check("stall_rdreq_pulses", npulse, 3);
      check("stall_rdreq_low", fifo_rdreq, 0);
      drain("p2");

      // Random ready, rd_en and upstream fill over 1000 words
      sent = 0;
      n = 0;
      p0 = n_pop;
      while ((sent < 1000 || src.size() != 0 || exp_q.size() != 0 || req_prev) && n < 20000) begin
         if (sent < 1000 && $urandom_range(3) != 0) begin
            src.push_back($urandom);
            sent++;
         end
         step($urandom_range(9) != 0, $urandom_range(1) == 1, 1'b0);
         n++;
      end
      check("random_timeout", n < 20000, 1);
      check("random_word_count", n_pop - p0, 1000);

      // rd_en dropped after two reads of a 4-beat packet
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) src.push_back(DW'(32'h200 + i));
      npulse = 0;
      n = 0;
      while (npulse < 2 && n < 20) begin
         step(1'b1, 1'b1, 1'b0);
         npulse += int'(req_prev);
         n++;
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
      check("rden_hold_valid", out_valid, 0);
      check("rden_hold_beat", beat_cnt, 2);
      check("rden_no_rdreq", fifo_rdreq, 0);
      drain("p4");

      // aclr with two words buffered and one in flight, mid-packet
      src.push_back(DW'(32'h300));
      drain("p5a");
      check("pre_rst_beat", beat_cnt, 1);
      for (int i = 0; i < 8; i++) src.push_back(DW'(32'h310 + i));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      check("pre_rst_valid", out_valid, 1);
      step(1'b1, 1'b0, 1'b1);
      check("aclr_valid", out_valid, 0);
      check("aclr_beat", beat_cnt, 0);
      check("aclr_rdreq", fifo_rdreq, 0);
      step(1'b1, 1'b1, 1'b0);
      check("post_rst_next_word", exp_q.size(), 0);
      drain("p5");

      check("final_scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
